// File: rtl/mem_bus_arbiter.sv
// Fetch/LSU arbiter for one shared memory bus, with an in-order owner-tag FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise data beats fetch.
module mem_bus_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                i_req_valid_i,
   output logic                i_req_ready_o,
   input  logic [ADDR_W-1:0]   i_req_addr_i,
   output logic                i_rsp_valid_o,
   input  logic                i_rsp_ready_i,
   output logic [DATA_W-1:0]   i_rsp_rdata_o,
   input  logic                i_flush_i,
   input  logic                d_req_valid_i,
   output logic                d_req_ready_o,
   input  logic [ADDR_W-1:0]   d_req_addr_i,
   input  logic [DATA_W-1:0]   d_req_wdata_i,
   input  logic [DATA_W/8-1:0] d_req_be_i,
   input  logic                d_req_we_i,
   output logic                d_rsp_valid_o,
   input  logic                d_rsp_ready_i,
   output logic [DATA_W-1:0]   d_rsp_rdata_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic                mem_we_o,
   input  logic                mem_rsp_valid_i,
   output logic                mem_rsp_ready_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOCK_I,
      LOCK_D
   } state_t;

   state_t state_q;
   state_t state_d;

   // tag 1 = data owner, 0 = fetch owner
   logic [MAX_OUTSTANDING-1:0] tag_q;
   logic [MAX_OUTSTANDING-1:0] disc_q;
   logic [PTR_W-1:0]           wr_ptr_q;
   logic [PTR_W-1:0]           rd_ptr_q;
   logic [CNT_W-1:0]           count_q;

   logic room;
   logic empty;
   logic grant_any;
   logic grant_d;
   logic issue;
   logic accept;
   logic pop;
   logic head_d;
   logic head_disc;
   logic prefer_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_favour_d_q;

   assign prefer_d = rr_favour_d_q;
`else
   assign prefer_d = 1'b1;
`endif

   assign room  = count_q < MAX_CNT;
   assign empty = count_q == '0;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Winner selection; a locked owner keeps the bus until its beat is taken
   always_comb begin
      state_d   = state_q;
      grant_any = 1'b0;
      grant_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_req_valid_i && i_req_valid_i) begin
               grant_any = 1'b1;
               grant_d   = prefer_d;
            end else if (d_req_valid_i) begin
               grant_any = 1'b1;
               grant_d   = 1'b1;
            end else if (i_req_valid_i) begin
               grant_any = 1'b1;
            end
         end
         LOCK_I: begin
            grant_any = i_req_valid_i;
         end
         LOCK_D: begin
            grant_any = d_req_valid_i;
            grant_d   = 1'b1;
         end
         default: begin
            grant_any = 1'b0;
         end
      endcase
      issue  = grant_any && room && !rst_i;
      accept = issue && mem_req_ready_i;
      if (issue && !mem_req_ready_i) begin
         state_d = grant_d ? LOCK_D : LOCK_I;
      end else if (accept || !grant_any) begin
         state_d = IDLE;
      end
   end

   assign mem_req_valid_o = issue;
   assign mem_addr_o      = grant_d ? d_req_addr_i : i_req_addr_i;
   assign mem_wdata_o     = grant_d ? d_req_wdata_i : '0;
   assign mem_be_o        = grant_d ? d_req_be_i : '1;
   assign mem_we_o        = grant_d && d_req_we_i;
   assign i_req_ready_o   = accept && !grant_d;
   assign d_req_ready_o   = accept && grant_d;

   assign head_d    = tag_q[rd_ptr_q];
   // a flush in the same cycle already discards the fetch at the head
   assign head_disc = disc_q[rd_ptr_q] || (i_flush_i && !head_d);

   always_comb begin
      i_rsp_valid_o   = 1'b0;
      d_rsp_valid_o   = 1'b0;
      mem_rsp_ready_o = 1'b0;
      if (!empty && !rst_i) begin
         if (head_d) begin
            d_rsp_valid_o   = mem_rsp_valid_i;
            mem_rsp_ready_o = d_rsp_ready_i;
         end else if (head_disc) begin
            mem_rsp_ready_o = 1'b1;
         end else begin
            i_rsp_valid_o   = mem_rsp_valid_i;
            mem_rsp_ready_o = i_rsp_ready_i;
         end
      end
   end

   assign pop           = mem_rsp_valid_i && mem_rsp_ready_o;
   assign i_rsp_rdata_o = mem_rdata_i;
   assign d_rsp_rdata_o = mem_rdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         disc_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            if (i_flush_i && !tag_q[k]) begin
               disc_q[k] <= 1'b1;
            end
         end
         if (accept) begin
            tag_q[wr_ptr_q]  <= grant_d;
            disc_q[wr_ptr_q] <= !grant_d && i_flush_i;
            wr_ptr_q         <= ptr_next(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
         if (accept && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !accept) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_favour_d_q <= 1'b1;
      end else if (accept) begin
         rr_favour_d_q <= !grant_d;
      end
   end
`endif

endmodule
